// File: rtl/cdc_hs_pkg.sv
// rtl/cdc_hs_pkg.sv - shared state type and constants for the handshake CDC receiver
//
// Contents:
//   hs_rx_state_t   receiver FSM states (ST_PRESENT used by the default build,
//                   ST_ONE/ST_TWO by the early-ack build)
//   MIN_SYNC_STAGE  shallowest request synchronizer that is accepted
package cdc_hs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_ONE     = 2'd2,
        ST_TWO     = 2'd3
    } hs_rx_state_t;

    localparam int MIN_SYNC_STAGE = 2;

endpackage

// File: rtl/data_sync_r.sv
// rtl/data_sync_r.sv - resettable multi-flop single-bit synchronizer
//
// Ports:
//   clk          destination clock
//   async_reset  asynchronous, active-high reset; clears every stage
//   d            asynchronous input bit
//   q            synchronized output (last stage of the chain)
// Parameters:
//   STAGES       number of flops in the chain (caller guarantees >= 2)
module data_sync_r #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic async_reset,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_handshake_rx.sv
// rtl/cdc_handshake_rx.sv - destination end of a 2-phase req/ack bus-transfer CDC
//
// The source toggles s_req_toggle with s_data held stable. The toggle is
// synchronized into clk, s_data is captured on the single-cycle edge strobe,
// presented on a valid/ready stream, and s_ack_toggle is returned so the source
// may send its next word.
//
// Ports:
//   clk           destination clock
//   async_reset   asynchronous, active-high reset
//   s_req_toggle  request toggle from the source domain (asynchronous)
//   s_data        source word, stable from req toggle until the source sees ack
//   s_ack_toggle  ack toggle back to the source domain (flop output)
//   m_valid       local word valid
//   m_data        local word (registered)
//   m_ready       local consumer accept
//   busy          FSM is holding at least one word
// Parameters:
//   DATA_WIDTH    width of the transferred word
//   SYNC_STAGE    request synchronizer depth (>= MIN_SYNC_STAGE)
// Build option:
//   CDC_HS_RX_EARLY_ACK_EN  when defined, ack on capture and absorb one extra
//                           word in a skid register (ST_IDLE/ST_ONE/ST_TWO);
//                           otherwise ack on local accept (ST_IDLE/ST_PRESENT).
module cdc_handshake_rx
    import cdc_hs_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SYNC_STAGE = 3
) (
    input  logic                  clk,
    input  logic                  async_reset,
    input  logic                  s_req_toggle,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ack_toggle,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy
);

    if (SYNC_STAGE < MIN_SYNC_STAGE) begin : g_bad_sync_stage
        $error("cdc_handshake_rx: SYNC_STAGE must be at least 2");
    end

    hs_rx_state_t          state;
    hs_rx_state_t          state_next;
    logic                  req_sync;
    logic                  req_d;
    logic                  new_req;
    logic                  accept;
    logic                  m_valid_next;
    logic [DATA_WIDTH-1:0] m_data_next;
    logic                  ack_next;
`ifdef CDC_HS_RX_EARLY_ACK_EN
    logic [DATA_WIDTH-1:0] skid;
    logic [DATA_WIDTH-1:0] skid_next;
`endif

    data_sync_r #(
        .STAGES      (SYNC_STAGE)
    ) u_req_sync (
        .clk         (clk),
        .async_reset (async_reset),
        .d           (s_req_toggle),
        .q           (req_sync)
    );

    // One strobe per source toggle, either direction. s_data is only looked
    // at in this cycle; the protocol keeps it stable until ack returns.
    assign new_req = req_sync ^ req_d;
    assign accept  = m_valid & m_ready;
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state        <= ST_IDLE;
            req_d        <= 1'b0;
            s_ack_toggle <= 1'b0;
            m_valid      <= 1'b0;
            m_data       <= '0;
`ifdef CDC_HS_RX_EARLY_ACK_EN
            skid         <= '0;
`endif
        end else begin
            state        <= state_next;
            req_d        <= req_sync;
            s_ack_toggle <= ack_next;
            m_valid      <= m_valid_next;
            m_data       <= m_data_next;
`ifdef CDC_HS_RX_EARLY_ACK_EN
            skid         <= skid_next;
`endif
        end
    end

    always_comb begin
        state_next   = state;
        m_valid_next = m_valid;
        m_data_next  = m_data;
        ack_next     = s_ack_toggle;
`ifdef CDC_HS_RX_EARLY_ACK_EN
        skid_next    = skid;
        case (state)
            ST_IDLE: begin
                if (new_req) begin
                    m_data_next  = s_data;
                    m_valid_next = 1'b1;
                    ack_next     = ~s_ack_toggle;
                    state_next   = ST_ONE;
                end
            end
            ST_ONE: begin
                // The word in m_data is already acked, so the source may have
                // launched the next one while the consumer is stalled.
                if (new_req && accept) begin
                    m_data_next = s_data;
                    ack_next    = ~s_ack_toggle;
                end else if (new_req) begin
                    // Park it; ack is withheld so no third word can arrive.
                    skid_next  = s_data;
                    state_next = ST_TWO;
                end else if (accept) begin
                    m_valid_next = 1'b0;
                    state_next   = ST_IDLE;
                end
            end
            ST_TWO: begin
                if (accept) begin
                    m_data_next = skid;
                    ack_next    = ~s_ack_toggle;
                    state_next  = ST_ONE;
                end
            end
            default: begin
                m_valid_next = 1'b0;
                state_next   = ST_IDLE;
            end
        endcase
`else
        case (state)
            ST_IDLE: begin
                if (new_req) begin
                    m_data_next  = s_data;
                    m_valid_next = 1'b1;
                    state_next   = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                // Ack only once the consumer has taken the word: exactly one
                // word is ever in flight.
                if (accept) begin
                    m_valid_next = 1'b0;
                    ack_next     = ~s_ack_toggle;
                    state_next   = ST_IDLE;
                end
            end
            default: begin
                m_valid_next = 1'b0;
                state_next   = ST_IDLE;
            end
        endcase
`endif
    end

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// tb/tb_cdc_handshake_rx.sv - self-checking bench for cdc_handshake_rx
`timescale 1ns/1ps
module tb_cdc_handshake_rx;

    localparam int DW         = 32;
    localparam int SYNC_STAGE = 3;
`ifdef CDC_HS_RX_EARLY_ACK_EN
    localparam bit EARLY_ACK  = 1'b1;
`else
    localparam bit EARLY_ACK  = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          src_clk = 1'b0;
    logic          async_reset;
    logic          s_req_toggle;
    logic [DW-1:0] s_data;
    logic          s_ack_toggle;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          busy;

    realtime dst_half = 5.0;
    realtime src_half = 5.0;

    int checks = 0;
    int errors = 0;
    logic exp_ack;

    logic [DW-1:0] exp_q[$];
    int  sent;
    bit  abort;

    always #(dst_half) clk = ~clk;
    always #(src_half) src_clk = ~src_clk;

    cdc_handshake_rx #(
        .DATA_WIDTH  (DW),
        .SYNC_STAGE  (SYNC_STAGE)
    ) dut (
        .clk          (clk),
        .async_reset  (async_reset),
        .s_req_toggle (s_req_toggle),
        .s_data       (s_data),
        .s_ack_toggle (s_ack_toggle),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .busy         (busy)
    );

    task automatic test_reset();
        async_reset  = 1'b1;
        s_req_toggle = 1'b0;
        s_data       = '0;
        m_ready      = 1'b0;
        exp_ack      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b required 0", m_valid); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %h required 0", m_data); end
        checks++; if (s_ack_toggle !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b required 0", s_ack_toggle); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        @(negedge clk);
        async_reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // T1: latency from req toggle to m_valid and ack placement.
    task automatic test_single_word();
        int lat;
        lat = 0;
        @(negedge clk);
        m_ready      = 1'b1;
        s_data       = 32'hDEAD_BEEF;
        s_req_toggle = ~s_req_toggle;
        for (int e = 1; e <= SYNC_STAGE + 4; e++) begin
            @(negedge clk);
            if (m_valid === 1'b1) begin
                lat = e;
                break;
            end
        end
        checks++; if (lat !== SYNC_STAGE + 1) begin errors++; $display("FAIL t1_latency: got %0d edges required %0d", lat, SYNC_STAGE + 1); end
        checks++; if (m_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t1_data: got %h required deadbeef", m_data); end
        checks++; if (s_ack_toggle !== (EARLY_ACK ? ~exp_ack : exp_ack)) begin errors++; $display("FAIL t1_ack_at_capture: got %b required %b", s_ack_toggle, EARLY_ACK ? ~exp_ack : exp_ack); end
        @(negedge clk);
        exp_ack = ~exp_ack;
        checks++; if (s_ack_toggle !== exp_ack) begin errors++; $display("FAIL t1_ack_after_accept: got %b required %b", s_ack_toggle, exp_ack); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_drop: got %b required 0", m_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_idle: got %b required 0", busy); end
        m_ready = 1'b0;
    endtask

    // T2: 20 cycles of backpressure hold the word and (default) the ack.
    task automatic test_backpressure();
        logic [DW-1:0] w;
        bit got;
        w = $urandom;
        got = 1'b0;
        @(negedge clk);
        m_ready      = 1'b0;
        s_data       = w;
        s_req_toggle = ~s_req_toggle;
        for (int c = 0; c < SYNC_STAGE + 4; c++) begin
            @(negedge clk);
            if (m_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL t2_wait_valid: m_valid=%b required 1", m_valid); end
        for (int c = 0; c < 20; c++) begin
            checks++; if (m_valid !== 1'b1 || m_data !== w) begin errors++; $display("FAIL t2_hold cycle %0d: valid=%b data=%h required 1/%h", c, m_valid, m_data, w); end
            checks++; if (s_ack_toggle !== (EARLY_ACK ? ~exp_ack : exp_ack)) begin errors++; $display("FAIL t2_ack_stall cycle %0d: got %b required %b", c, s_ack_toggle, EARLY_ACK ? ~exp_ack : exp_ack); end
            @(negedge clk);
        end
        m_ready = 1'b1;
        @(negedge clk);
        exp_ack = ~exp_ack;
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL t2_valid_drop: got %b required 0", m_valid); end
        checks++; if (s_ack_toggle !== exp_ack) begin errors++; $display("FAIL t2_ack_final: got %b required %b", s_ack_toggle, exp_ack); end
    endtask

`ifdef CDC_HS_RX_EARLY_ACK_EN
    // T4: new word arrives in the same cycle the held word is accepted.
    task automatic test_simultaneous();
        logic [DW-1:0] w1, w2;
        bit got;
        w1 = $urandom;
        w2 = $urandom;
        got = 1'b0;
        @(negedge clk);
        m_ready      = 1'b0;
        s_data       = w1;
        s_req_toggle = ~s_req_toggle;
        for (int c = 0; c < SYNC_STAGE + 4; c++) begin
            @(negedge clk);
            if (m_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        exp_ack = ~exp_ack;
        checks++; if (!got || s_ack_toggle !== exp_ack) begin errors++; $display("FAIL t4_first_capture: valid=%b ack=%b required 1/%b", m_valid, s_ack_toggle, exp_ack); end
        s_data       = w2;
        s_req_toggle = ~s_req_toggle;
        repeat (SYNC_STAGE) @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        exp_ack = ~exp_ack;
        checks++; if (m_valid !== 1'b1 || m_data !== w2) begin errors++; $display("FAIL t4_swap: valid=%b data=%h required 1/%h", m_valid, m_data, w2); end
        checks++; if (s_ack_toggle !== exp_ack) begin errors++; $display("FAIL t4_ack_once: got %b required %b", s_ack_toggle, exp_ack); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t4_busy: got %b required 1", busy); end
        @(negedge clk);
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0 || s_ack_toggle !== exp_ack) begin errors++; $display("FAIL t4_drain: valid=%b ack=%b required 0/%b", m_valid, s_ack_toggle, exp_ack); end
    endtask
`endif

    // T5: asynchronous reset while a word is held.
    task automatic test_reset_mid_transfer();
        logic [DW-1:0] w;
        bit got;
        w = $urandom;
        got = 1'b0;
        @(negedge clk);
        m_ready      = 1'b0;
        s_data       = $urandom;
        s_req_toggle = ~s_req_toggle;
        for (int c = 0; c < SYNC_STAGE + 4; c++) begin
            @(negedge clk);
            if (m_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL t5_wait_valid: m_valid=%b required 1", m_valid); end
        #2;
        async_reset  = 1'b1;
        s_req_toggle = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL t5_async_valid: got %b required 0", m_valid); end
        checks++; if (s_ack_toggle !== 1'b0) begin errors++; $display("FAIL t5_async_ack: got %b required 0", s_ack_toggle); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_async_busy: got %b required 0", busy); end
        exp_ack = 1'b0;
        @(negedge clk);
        async_reset = 1'b0;
        @(negedge clk);
        got          = 1'b0;
        m_ready      = 1'b1;
        s_data       = w;
        s_req_toggle = ~s_req_toggle;
        for (int c = 0; c < SYNC_STAGE + 4; c++) begin
            @(negedge clk);
            if (m_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        checks++; if (!got || m_data !== w) begin errors++; $display("FAIL t5_after_reset: valid=%b data=%h required 1/%h", m_valid, m_data, w); end
        @(negedge clk);
        exp_ack = ~exp_ack;
        m_ready = 1'b0;
        checks++; if (s_ack_toggle !== exp_ack) begin errors++; $display("FAIL t5_after_reset_ack: got %b required %b", s_ack_toggle, exp_ack); end
    endtask

    // T3/T6: free-running source on its own clock, random consumer stalls.
    task automatic test_burst(input realtime dh, input realtime sh, input int n);
        int accepted;
        int acks;
        logic last_ack;
        logic src_ack;
        int max_out;
        dst_half = dh;
        src_half = sh;
        exp_q.delete();
        sent     = 0;
        abort    = 1'b0;
        accepted = 0;
        acks     = 0;
        max_out  = EARLY_ACK ? 2 : 1;
        repeat (4) @(negedge clk);
        last_ack = s_ack_toggle;
        src_ack  = s_ack_toggle;
        fork
            begin
                for (int i = 0; i < n && !abort; i++) begin
                    bit got;
                    logic [DW-1:0] w;
                    got = 1'b0;
                    @(negedge src_clk);
                    w = $urandom;
                    exp_q.push_back(w);
                    sent++;
                    s_data       = w;
                    s_req_toggle = ~s_req_toggle;
                    for (int c = 0; c < 400 && !abort; c++) begin
                        @(posedge src_clk);
                        if (s_ack_toggle !== src_ack) begin
                            src_ack = s_ack_toggle;
                            got = 1'b1;
                            break;
                        end
                    end
                    if (!got && !abort) begin
                        checks++; errors++;
                        $display("FAIL burst_ack_timeout word %0d: ack=%b required %b", i, s_ack_toggle, ~src_ack);
                        abort = 1'b1;
                    end
                end
            end
            begin
                for (int cyc = 0; cyc < 50 * n && accepted < n && !abort; cyc++) begin
                    @(negedge clk);
                    if (s_ack_toggle !== last_ack) begin
                        acks++;
                        last_ack = s_ack_toggle;
                    end
                    checks++; if (busy !== m_valid) begin errors++; $display("FAIL burst_busy: busy=%b required %b", busy, m_valid); end
                    checks++;
                    if (EARLY_ACK ? (acks < accepted || acks > accepted + 1) : (acks != accepted)) begin
                        errors++; $display("FAIL burst_ack_count: acks=%0d accepted=%0d", acks, accepted);
                    end
                    checks++; if (sent - accepted > max_out) begin errors++; $display("FAIL burst_outstanding: got %0d required <= %0d", sent - accepted, max_out); end
                    m_ready = 1'($urandom_range(0, 1));
                    if (m_valid === 1'b1 && m_ready === 1'b1) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++; $display("FAIL burst_extra_word: got %h required none", m_data);
                        end else begin
                            logic [DW-1:0] e;
                            e = exp_q.pop_front();
                            if (m_data !== e) begin errors++; $display("FAIL burst_data word %0d: got %h required %h", accepted, m_data, e); end
                        end
                        accepted++;
                    end
                end
                checks++; if (accepted !== n) begin errors++; $display("FAIL burst_count: got %0d words required %0d", accepted, n); end
                abort = 1'b1;
            end
        join
        @(negedge clk);
        m_ready = 1'b0;
        repeat (SYNC_STAGE + 4) @(negedge clk);
        exp_ack = s_ack_toggle;
        checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL burst_idle_after: valid=%b busy=%b required 0/0", m_valid, busy); end
        dst_half = 5.0;
        src_half = 5.0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
`ifdef CDC_HS_RX_EARLY_ACK_EN
        test_simultaneous();
`endif
        test_reset_mid_transfer();
        test_burst(5.0, 5.0, 256);
        test_burst(13.5, 5.0, 256);
        test_burst(5.0, 13.5, 256);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
